// File: rtl/mem_bus_if_pkg.sv
// Shared encodings and constants for the data-side bus bridge.
package mem_bus_if_pkg;

  typedef enum logic [1:0] {
    BUS_IDLE       = 2'b00,
    BUS_BUSY       = 2'b01,
    BUS_WAIT_STALL = 2'b11
  } bus_state_t;

  localparam logic [31:0] ZeroWord     = '0;
  localparam logic        WriteEnable  = 1'b1;
  localparam logic        WriteDisable = 1'b0;
  localparam logic        Stop         = 1'b1;
  localparam logic        NoStop       = 1'b0;

endpackage

// File: rtl/mem_bus_if.sv
// Memory-stage to Wishbone-style bus master bridge with read-data hold across pipeline stalls.
// Optional bus timeout abort enabled by defining MEM_BUS_TIMEOUT_EN (adds bus_err_o).
module mem_bus_if
  import mem_bus_if_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic              cpu_ce_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  input  logic              cpu_we_i,
  input  logic [3:0]        cpu_sel_i,
  output logic [DATA_W-1:0] cpu_data_o,
  output logic              stallreq,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_data_o,
  output logic              bus_we_o,
  output logic [3:0]        bus_sel_o,
  output logic              bus_stb_o,
  output logic              bus_cyc_o,
  input  logic [DATA_W-1:0] bus_data_i,
  input  logic              bus_ack_i
`ifdef MEM_BUS_TIMEOUT_EN
  ,
  output logic              bus_err_o
`endif
);

  bus_state_t        r_state;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_data;
  logic              r_bus_we;
  logic [3:0]        r_bus_sel;
  logic              r_bus_stb;
  logic              r_bus_cyc;
  logic [DATA_W-1:0] r_rd_buf;

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                  $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] r_cnt;
  logic             r_bus_err;
  assign bus_err_o = r_bus_err;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= BUS_IDLE;
      r_bus_addr <= '0;
      r_bus_data <= '0;
      r_bus_we   <= WriteDisable;
      r_bus_sel  <= '0;
      r_bus_stb  <= 1'b0;
      r_bus_cyc  <= 1'b0;
      r_rd_buf   <= '0;
`ifdef MEM_BUS_TIMEOUT_EN
      r_cnt      <= '0;
      r_bus_err  <= 1'b0;
`endif
    end else begin
`ifdef MEM_BUS_TIMEOUT_EN
      r_bus_err <= 1'b0;
`endif
      case (r_state)
        BUS_IDLE: begin
          if (cpu_ce_i && !flush) begin
            r_bus_addr <= cpu_addr_i;
            r_bus_data <= cpu_data_i;
            r_bus_we   <= cpu_we_i;
            r_bus_sel  <= cpu_sel_i;
            r_bus_stb  <= 1'b1;
            r_bus_cyc  <= 1'b1;
            r_state    <= BUS_BUSY;
`ifdef MEM_BUS_TIMEOUT_EN
            r_cnt      <= '0;
`endif
          end
        end
        BUS_BUSY: begin
          // Priority: flush, then ack, then timeout; otherwise hold the bus stable.
          if (flush) begin
            r_bus_addr <= '0;
            r_bus_data <= '0;
            r_bus_we   <= WriteDisable;
            r_bus_sel  <= '0;
            r_bus_stb  <= 1'b0;
            r_bus_cyc  <= 1'b0;
            r_rd_buf   <= '0;
            r_state    <= BUS_IDLE;
          end else if (bus_ack_i) begin
            r_bus_addr <= '0;
            r_bus_data <= '0;
            r_bus_we   <= WriteDisable;
            r_bus_sel  <= '0;
            r_bus_stb  <= 1'b0;
            r_bus_cyc  <= 1'b0;
            if (cpu_we_i == WriteDisable) begin
              r_rd_buf <= bus_data_i;
            end
            r_state <= (stall != 6'd0) ? BUS_WAIT_STALL : BUS_IDLE;
          end
`ifdef MEM_BUS_TIMEOUT_EN
          else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_bus_addr <= '0;
            r_bus_data <= '0;
            r_bus_we   <= WriteDisable;
            r_bus_sel  <= '0;
            r_bus_stb  <= 1'b0;
            r_bus_cyc  <= 1'b0;
            r_rd_buf   <= '0;
            r_bus_err  <= 1'b1;
            r_state    <= BUS_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
`endif
        end
        BUS_WAIT_STALL: begin
          if (flush) begin
            r_rd_buf <= '0;
            r_state  <= BUS_IDLE;
          end else if (stall == 6'd0) begin
            r_state <= BUS_IDLE;
          end
        end
        default: r_state <= BUS_IDLE;
      endcase
    end
  end

  always_comb begin
    stallreq   = NoStop;
    cpu_data_o = '0;
    case (r_state)
      BUS_IDLE: begin
        stallreq = (cpu_ce_i && !flush) ? Stop : NoStop;
      end
      BUS_BUSY: begin
        stallreq = bus_ack_i ? NoStop : Stop;
        if (bus_ack_i && cpu_we_i == WriteDisable) begin
          cpu_data_o = bus_data_i;
        end
      end
      BUS_WAIT_STALL: begin
        cpu_data_o = r_rd_buf;
      end
      default: ;
    endcase
  end

  assign bus_addr_o = r_bus_addr;
  assign bus_data_o = r_bus_data;
  assign bus_we_o   = r_bus_we;
  assign bus_sel_o  = r_bus_sel;
  assign bus_stb_o  = r_bus_stb;
  assign bus_cyc_o  = r_bus_cyc;

endmodule

// File: tb/tb_mem_bus_if.sv
// Randomized self-checking bench for mem_bus_if against a transaction-level reference model.
// Also exercises the bus_err_o path when built with MEM_BUS_TIMEOUT_EN.
module tb_mem_bus_if;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        cpu_ce_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_data_i;
  logic        cpu_we_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_data_o;
  logic        stallreq;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_data_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic        bus_stb_o;
  logic        bus_cyc_o;
  logic [31:0] bus_data_i;
  logic        bus_ack_i;
`ifdef MEM_BUS_TIMEOUT_EN
  logic        bus_err_o;
`endif

  mem_bus_if #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .cpu_ce_i(cpu_ce_i), .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
    .cpu_we_i(cpu_we_i), .cpu_sel_i(cpu_sel_i), .cpu_data_o(cpu_data_o),
    .stallreq(stallreq), .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o),
    .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o), .bus_stb_o(bus_stb_o),
    .bus_cyc_o(bus_cyc_o), .bus_data_i(bus_data_i), .bus_ack_i(bus_ack_i)
`ifdef MEM_BUS_TIMEOUT_EN
    , .bus_err_o(bus_err_o)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model: an outstanding transaction record plus a held read value.
  bit          m_active;
  bit          m_hold;
  logic [31:0] m_addr, m_wdata, m_rdbuf;
  logic        m_we;
  logic [3:0]  m_sel;
  int unsigned m_wait;
  logic        m_err;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    else
      n_pass++;
  endtask

  task automatic check_all();
    logic [31:0] e_data;
    logic        e_stallreq;
    if (m_active) begin
      e_stallreq = !bus_ack_i;
      e_data     = (bus_ack_i && !cpu_we_i) ? bus_data_i : 32'h0;
    end else if (m_hold) begin
      e_stallreq = 1'b0;
      e_data     = m_rdbuf;
    end else begin
      e_stallreq = cpu_ce_i && !flush;
      e_data     = 32'h0;
    end
    check_eq("bus_addr", 64'(bus_addr_o), m_active ? 64'(m_addr) : 64'h0);
    check_eq("bus_data", 64'(bus_data_o), m_active ? 64'(m_wdata) : 64'h0);
    check_eq("bus_we",   64'(bus_we_o),   m_active ? 64'(m_we) : 64'h0);
    check_eq("bus_sel",  64'(bus_sel_o),  m_active ? 64'(m_sel) : 64'h0);
    check_eq("bus_stb",  64'(bus_stb_o),  64'(m_active));
    check_eq("bus_cyc",  64'(bus_cyc_o),  64'(m_active));
    check_eq("stallreq", 64'(stallreq),   64'(e_stallreq));
    check_eq("cpu_data", 64'(cpu_data_o), 64'(e_data));
`ifdef MEM_BUS_TIMEOUT_EN
    check_eq("bus_err",  64'(bus_err_o),  64'(m_err));
`endif
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    m_err = 1'b0;
    if (!rst) begin
      m_active = 0; m_hold = 0; m_rdbuf = '0;
      m_addr = '0; m_wdata = '0; m_we = 0; m_sel = '0; m_wait = 0;
    end else if (m_active) begin
      if (flush) begin
        m_active = 0; m_rdbuf = '0;
      end else if (bus_ack_i) begin
        m_active = 0;
        if (!cpu_we_i) m_rdbuf = bus_data_i;
        m_hold = (stall != 6'd0);
      end else begin
        m_wait++;
`ifdef MEM_BUS_TIMEOUT_EN
        if (m_wait >= TO) begin
          m_active = 0; m_rdbuf = '0; m_err = 1'b1;
        end
`endif
      end
    end else if (m_hold) begin
      if (flush) begin
        m_hold = 0; m_rdbuf = '0;
      end else if (stall == 6'd0) begin
        m_hold = 0;
      end
    end else if (cpu_ce_i && !flush) begin
      m_active = 1; m_wait = 0;
      m_addr = cpu_addr_i; m_wdata = cpu_data_i; m_we = cpu_we_i; m_sel = cpu_sel_i;
    end
  endtask

  // Apply one cycle of inputs, check all outputs mid-cycle, then cross the edge.
  task automatic tick(input logic r, input logic ce, input logic [31:0] a, input logic [31:0] d,
                      input logic we, input logic [3:0] sel, input logic [5:0] st,
                      input logic fl, input logic ack, input logic [31:0] bd);
    rst = r; cpu_ce_i = ce; cpu_addr_i = a; cpu_data_i = d; cpu_we_i = we;
    cpu_sel_i = sel; stall = st; flush = fl; bus_ack_i = ack; bus_data_i = bd;
    #2;
    check_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_active = 0; m_hold = 0; m_rdbuf = '0; m_addr = '0; m_wdata = '0;
    m_we = 0; m_sel = '0; m_wait = 0; m_err = 0;
    rst = 0; cpu_ce_i = 0; cpu_addr_i = '0; cpu_data_i = '0; cpu_we_i = 0;
    cpu_sel_i = '0; stall = '0; flush = 0; bus_ack_i = 0; bus_data_i = '0;
    @(posedge clk); #1;
    tick(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Load with ack on the first BUSY cycle.
    tick(1, 1, 32'h40, 0, 0, 4'hF, 0, 0, 0, 0);
    check_eq("t1_cyc", 64'(bus_cyc_o), 64'h1);
    tick(1, 1, 32'h40, 0, 0, 4'hF, 0, 0, 1, 32'hDEADBEEF);
    tick(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("t1_idle_cyc", 64'(bus_cyc_o), 64'h0);

    // Store with three wait states.
    tick(1, 1, 32'h80, 32'h12345678, 1, 4'b0011, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick(1, 1, 32'h80, 32'h12345678, 1, 4'b0011, 0, 0, 0, 0);
    check_eq("t2_sel", 64'(bus_sel_o), 64'h3);
    tick(1, 1, 32'h80, 32'h12345678, 1, 4'b0011, 0, 0, 1, 32'h5555AAAA);
    tick(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Load acked while the pipeline is stalled.
    tick(1, 1, 32'h100, 0, 0, 4'hF, 6'b000011, 0, 0, 0);
    tick(1, 1, 32'h100, 0, 0, 4'hF, 6'b000011, 0, 1, 32'hCAFEF00D);
    for (int i = 0; i < 3; i++) tick(1, 1, 32'h100, 0, 0, 4'hF, 6'b000011, 0, 0, 0);
    check_eq("t3_hold", 64'(cpu_data_o), 64'hCAFEF00D);
    tick(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("t3_released", 64'(cpu_data_o), 64'h0);

    // Flush and ack together while BUSY.
    tick(1, 1, 32'h200, 0, 0, 4'hF, 6'b000001, 0, 0, 0);
    tick(1, 1, 32'h200, 0, 0, 4'hF, 6'b000001, 1, 1, 32'h11112222);
    tick(1, 0, 0, 0, 0, 0, 6'b000001, 0, 0, 0);
    check_eq("t4_cyc", 64'(bus_cyc_o), 64'h0);
    check_eq("t4_stallreq", 64'(stallreq), 64'h0);

    // Reset mid-transaction, then a stray ack.
    tick(1, 1, 32'h300, 32'h99, 1, 4'h1, 0, 0, 0, 0);
    tick(0, 1, 32'h300, 32'h99, 1, 4'h1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77);
    check_eq("t5_cyc", 64'(bus_cyc_o), 64'h0);

`ifdef MEM_BUS_TIMEOUT_EN
    // No ack: abort after TO BUSY cycles.
    tick(1, 1, 32'h400, 0, 0, 4'hF, 0, 0, 0, 0);
    for (int i = 0; i < int'(TO); i++) tick(1, 1, 32'h400, 0, 0, 4'hF, 0, 0, 0, 0);
    check_eq("t6_err", 64'(bus_err_o), 64'h1);
    tick(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("t6_err_clear", 64'(bus_err_o), 64'h0);
`endif

    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(99) != 0),
           $urandom_range(1),
           $urandom(), $urandom(),
           $urandom_range(1),
           4'($urandom_range(15)),
           ($urandom_range(9) < 3) ? 6'($urandom_range(63)) : 6'd0,
           ($urandom_range(99) < 8),
           ($urandom_range(9) < 4),
           $urandom());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
